// File: rtl/alu_pkg.sv
// Shared ALU operation codes, LEGv8 opcode constants and decoder FIFO entry type.
// Optional per-entry illegal flag is enabled with the ALU_DEC_ILLEGAL_EN macro.
package alu_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned OPC_W = 11;

    localparam logic [OP_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [OP_W-1:0] ALU_ORR   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [OP_W-1:0] ALU_PASSB = 4'b0111;
    localparam logic [OP_W-1:0] ALU_NOR   = 4'b1100;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    // Operation emitted for opcodes missing from the decode table
`ifdef ALU_DEC_ILLEGAL_EN
    localparam logic [OP_W-1:0] ALU_UNLISTED = ALU_NOR;
`else
    localparam logic [OP_W-1:0] ALU_UNLISTED = ALU_ADD;
`endif

    typedef struct packed {
        logic [OP_W-1:0] operation;
        logic            imm_sel;
`ifdef ALU_DEC_ILLEGAL_EN
        logic            illegal;
`endif
    } alu_entry_t;

endpackage

// File: rtl/alu_op_lut.sv
// Combinational opcode -> ALU operation/immediate-select lookup.
// Illegal flag output present only with ALU_DEC_ILLEGAL_EN.
module alu_op_lut
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output logic [OP_W-1:0]  o_operation,
    output logic             o_imm_sel
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    output logic             o_illegal
`endif
);

    // Full 11-bit opcodes first, then the shorter I-type and CB-type prefixes
    always_comb begin
        o_operation = ALU_UNLISTED;
        o_imm_sel   = 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
        o_illegal   = 1'b0;
`endif
        if (i_opcode == OPC_ADD) begin
            o_operation = ALU_ADD;
        end else if (i_opcode == OPC_SUB) begin
            o_operation = ALU_SUB;
        end else if (i_opcode == OPC_AND) begin
            o_operation = ALU_AND;
        end else if (i_opcode == OPC_ORR) begin
            o_operation = ALU_ORR;
        end else if (i_opcode == OPC_LDUR || i_opcode == OPC_STUR) begin
            o_operation = ALU_ADD;
            o_imm_sel   = 1'b1;
        end else if (i_opcode[10:1] == OPC_ADDI) begin
            o_operation = ALU_ADD;
            o_imm_sel   = 1'b1;
        end else if (i_opcode[10:1] == OPC_SUBI) begin
            o_operation = ALU_SUB;
            o_imm_sel   = 1'b1;
        end else if (i_opcode[10:3] == OPC_CBZ) begin
            o_operation = ALU_PASSB;
        end else begin
            o_operation = ALU_UNLISTED;
`ifdef ALU_DEC_ILLEGAL_EN
            o_illegal   = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/alu_op_decoder.sv
// LEGv8 ALU-control decoder with a DEPTH-entry buffer of decoded entries.
// Optional illegal-opcode port enabled with the ALU_DEC_ILLEGAL_EN macro.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [OP_W-1:0] operation,
    output logic            imm_sel,
    output logic            op_valid,
    input  logic            op_ready
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    alu_entry_t       r_mem [DEPTH];
    alu_entry_t       r_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_op_valid;
    logic             r_ready;

    alu_entry_t       w_din;
    alu_entry_t       w_head_next;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_inc;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_instr;

    assign w_unused_instr = ^instr[20:0];

    alu_op_lut u_lut (
        .i_opcode    (instr[31:21]),
        .o_operation (w_din.operation),
        .o_imm_sel   (w_din.imm_sel)
`ifdef ALU_DEC_ILLEGAL_EN
        ,
        .o_illegal   (w_din.illegal)
`endif
    );

    // Next-state: pointers, count and the registered head-of-queue view
    always_comb begin
        w_push        = instr_valid && r_ready;
        w_pop         = r_op_valid && op_ready;
        w_rd_ptr_inc  = r_rd_ptr + PTR_W'(1);
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        w_head_next   = r_head;

        if (w_push) w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
        if (w_pop)  w_rd_ptr_next = w_rd_ptr_inc;

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase

        // Empty after this edge: head keeps the last-popped entry
        if (w_count_next != '0) begin
            if (r_count == '0) begin
                w_head_next = w_din;
            end else if (w_pop) begin
                w_head_next = (r_count >= CNT_W'(2)) ? r_mem[w_rd_ptr_inc] : w_din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_op_valid <= 1'b0;
            r_ready    <= 1'b0;
            r_head     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            r_count    <= w_count_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_op_valid <= (w_count_next != '0);
            r_ready    <= (w_count_next < CNT_W'(DEPTH));
            r_head     <= w_head_next;
            if (w_push) r_mem[r_wr_ptr] <= w_din;
        end
    end

    assign instr_ready = r_ready;
    assign op_valid    = r_op_valid;
    assign operation   = r_head.operation;
    assign imm_sel     = r_head.imm_sel;
`ifdef ALU_DEC_ILLEGAL_EN
    assign illegal     = r_head.illegal;
`endif

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 instr  input  32  LEGv8 instruction word; opcode field instr[31:21].
REQ-004 instr_valid  input  1  instr is presented this cycle.
REQ-005 instr_ready  output  1  decoder can accept instr this cycle.
REQ-006 operation  output  4  ALU operation code for the ALU operation port.
REQ-007 imm_sel  output  1  1 = ALU input2 comes from the immediate field; 0 = from the register.
REQ-008 op_valid  output  1  operation/imm_sel hold a decoded entry.
REQ-009 op_ready  input  1  the downstream ALU stage accepts the entry this cycle.
REQ-010 illegal  output  1  the head entry's opcode is unrecognised (present only with ALU_DEC_ILLEGAL_EN).
REQ-011 Parameter DEPTH, default 2, sets the number of output buffer entries; legal values are 2 or 4.

Function
REQ-012 Decode table (opcode -> operation, imm_sel):
  - ADD 10001011000 -> 0010, 0.
  - SUB 11001011000 -> 0110, 0.
  - AND 10001010000 -> 0000, 0.
  - ORR 10101010000 -> 0001, 0.
  - LDUR 11111000010 -> 0010, 1.
  - STUR 11111000000 -> 0010, 1.
  - ADDI instr[31:22]=1001000100 -> 0010, 1.
  - SUBI instr[31:22]=1101000100 -> 0110, 1.
  - CBZ instr[31:24]=10110100 -> 0111, 0.
REQ-013 Every opcode not listed in REQ-012 decodes to operation 1100, imm_sel 0, and is marked illegal.
REQ-014 A transfer in occurs when instr_valid && instr_ready; a transfer out occurs when op_valid && op_ready.
REQ-015 Decoding is combinational; the decoded result, not the raw instr, is written into a DEPTH-entry FIFO.
REQ-016 Latency: an instr accepted in cycle N into an empty FIFO appears with op_valid=1 in cycle N+1; there is no combinational path from instr to the outputs.
REQ-017 instr_ready = (count < DEPTH); it depends only on registered state and never on op_ready.
REQ-018 Full FIFO with a pop in the same cycle: instr_ready stays 0 that cycle (no push-through); the freed slot is usable in the next cycle.
REQ-019 Simultaneous push and pop when 0 < count < DEPTH: count is unchanged, entry order is preserved, and no entry is lost or duplicated.
REQ-020 Empty FIFO: op_valid=0; operation/imm_sel/illegal hold the last-popped values; op_ready is ignored.
REQ-021 Read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH and saturates at neither end by design.
REQ-022 While op_valid=1 and op_ready=0, operation, imm_sel and illegal shall remain stable.

Reset
REQ-023 On rst assertion, asynchronously: count=0, pointers=0, op_valid=0, operation=0000, imm_sel=0, illegal=0, instr_ready=0 while rst is high.
REQ-024 A reset asserted mid-operation discards all buffered entries, and no out-transfer completes in that cycle.
REQ-025 instr_ready rises in the first clock edge after rst deasserts.

Configuration
REQ-026 Macro ALU_DEC_ILLEGAL_EN.
REQ-027 When the macro is defined, the illegal port and the per-entry illegal bit exist, and illegal entries are still delivered in order.
REQ-028 When the macro is undefined, the illegal port is absent, unlisted opcodes decode to 0010/imm_sel 0 with no flag, and the FIFO width is 5 bits.

Structure
REQ-029 Shared package alu_pkg holds the 4-bit operation localparams (AND, ORR, ADD, SUB, PASSB, NOR) and the opcode constants of REQ-012.
REQ-030 One sub-module, alu_op_lut, is purely combinational (instr[31:21] -> operation, imm_sel, illegal); the FIFO and handshake logic live in alu_op_decoder.

Verification
REQ-031 Reset then ADD (0x8B000000) with op_ready=1 -> cycle+1: op_valid=1, operation=0010, imm_sel=0; cycle+2: op_valid=0.
REQ-032 Back-to-back SUB, ORR, LDUR with op_ready=0 (DEPTH=2) -> instr_ready drops after 2 accepts; then op_ready=1 -> outputs 0110/0, then 0001/0; LDUR is accepted only after the first pop, then emerges as 0010/1.
REQ-033 Continuous stream of 8 mixed instrs, op_ready toggling every cycle -> output sequence equals input order, with no loss or duplication.
REQ-034 opcode 0x7FF with ALU_DEC_ILLEGAL_EN -> operation=1100, illegal=1; without the macro -> operation=0010.
REQ-035 rst pulsed with 2 entries buffered -> op_valid=0 immediately (asynchronously); the next accepted CBZ (0xB4000000) emerges as 0111/0.
